axil_reg_bridge: RTL and testbench

//  AXI4-Lite slave bridge sitting directly upstream of a bank of NUM_REGS software-writable

---
 rtl/axil_reg_bridge_pkg.sv | 30 +++
 rtl/axil_reg_bridge_wr.sv | 96 +++++++++
 rtl/axil_reg_bridge.sv | 95 +++++++++
 tb/tb_axil_reg_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_reg_bridge_pkg.sv
// axil_reg_bridge_pkg: shared constants and FSM encodings for the AXI4-Lite register bridge.
// Contents: response codes, strobe width, write/read FSM state types.
// Config macro: AXIL_BRIDGE_SLVERR_EN selects SLVERR instead of OKAY for decode misses.
package axil_reg_bridge_pkg;

    localparam int          DATA_W      = 32;
    localparam int          STRB_WIDTH  = DATA_W / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

`ifdef AXIL_BRIDGE_SLVERR_EN
    localparam logic [1:0]  RESP_MISS   = RESP_SLVERR;
`else
    localparam logic [1:0]  RESP_MISS   = RESP_OKAY;
`endif

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axil_reg_bridge_wr.sv
// axil_reg_bridge_wr: AXI4-Lite write channel, address decode and byte-strobe merge.
// Ports: CLK/RST; S_AW* and S_W* accept address/data in any order; S_B* write response;
//        REG_WEN one-cycle one-hot pulse, REG_WDATA merged value, REG_RDATA current bank contents.
// Config macro: AXIL_BRIDGE_SLVERR_EN (through RESP_MISS in the package).
module axil_reg_bridge_wr
    import axil_reg_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [ADDR_WIDTH-1:0]          S_AWADDR,
    input  logic                           S_AWVALID,
    output logic                           S_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_WDATA,
    input  logic [STRB_WIDTH-1:0]          S_WSTRB,
    input  logic                           S_WVALID,
    output logic                           S_WREADY,
    output logic [1:0]                     S_BRESP,
    output logic                           S_BVALID,
    input  logic                           S_BREADY,
    output logic [NUM_REGS-1:0]            REG_WEN,
    output logic [DATA_WIDTH-1:0]          REG_WDATA,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] REG_RDATA
);

    localparam int                    IW   = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NREG = ADDR_WIDTH'(NUM_REGS);

    wr_state_t               state, state_nxt;
    logic                    aw_hs, w_hs;
    logic                    hit_q;
    logic [IW-1:0]           idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic [1:0]              bresp_q;
    logic [DATA_WIDTH-1:0]   cur;

    // Readies are forced low while RST is held so the bus sees a quiet slave during reset.
    assign S_AWREADY = !RST && (state == W_IDLE || state == W_HAVE_W);
    assign S_WREADY  = !RST && (state == W_IDLE || state == W_HAVE_AW);
    assign aw_hs     = S_AWVALID && S_AWREADY;
    assign w_hs      = S_WVALID && S_WREADY;
    assign S_BVALID  = state == W_RESP;
    assign S_BRESP   = bresp_q;
    assign cur       = REG_RDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_nxt = state;
        case (state)
            W_IDLE:    state_nxt = aw_hs && w_hs ? W_COMMIT : aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : W_IDLE;
            W_HAVE_AW: state_nxt = w_hs ? W_COMMIT : W_HAVE_AW;
            W_HAVE_W:  state_nxt = aw_hs ? W_COMMIT : W_HAVE_W;
            W_COMMIT:  state_nxt = W_RESP;
            W_RESP:    state_nxt = S_BREADY ? W_IDLE : W_RESP;
            default:   state_nxt = W_IDLE;
        endcase
    end

    // Merge uses the register's value during the commit cycle, so unstrobed bytes are preserved.
    always_comb begin
        REG_WEN   = '0;
        REG_WDATA = '0;
        if (state == W_COMMIT) begin
            REG_WEN = hit_q ? NUM_REGS'(1) << idx_q : '0;
            for (int b = 0; b < STRB_WIDTH; b++)
                REG_WDATA[b*8 +: 8] = wstrb_q[b] ? wdata_q[b*8 +: 8] : cur[b*8 +: 8];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= W_IDLE;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            if (aw_hs) begin
                hit_q <= (S_AWADDR >> 2) < NREG;
                idx_q <= S_AWADDR[IW+1:2];
            end
            if (w_hs) begin
                wdata_q <= S_WDATA;
                wstrb_q <= S_WSTRB;
            end
            if (state == W_COMMIT)
                bresp_q <= hit_q ? RESP_OKAY : RESP_MISS;
        end
    end

endmodule

// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge: AXI4-Lite slave in front of a bank of NUM_REGS 32-bit registers.
// Ports: CLK/RST (async, active high); S_AW*/S_W*/S_B* write channels; S_AR*/S_R* read channels;
//        REG_WEN/REG_WDATA drive the bank, REG_RDATA (reg i at [i*DATA_WIDTH +: DATA_WIDTH]) is read back.
// Config macro: AXIL_BRIDGE_SLVERR_EN makes decode misses answer SLVERR instead of OKAY.
module axil_reg_bridge
    import axil_reg_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [ADDR_WIDTH-1:0]          S_AWADDR,
    input  logic                           S_AWVALID,
    output logic                           S_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_WDATA,
    input  logic [STRB_WIDTH-1:0]          S_WSTRB,
    input  logic                           S_WVALID,
    output logic                           S_WREADY,
    output logic [1:0]                     S_BRESP,
    output logic                           S_BVALID,
    input  logic                           S_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_ARADDR,
    input  logic                           S_ARVALID,
    output logic                           S_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_RDATA,
    output logic [1:0]                     S_RRESP,
    output logic                           S_RVALID,
    input  logic                           S_RREADY,
    output logic [NUM_REGS-1:0]            REG_WEN,
    output logic [DATA_WIDTH-1:0]          REG_WDATA,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] REG_RDATA
);

    localparam int                    IW   = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NREG = ADDR_WIDTH'(NUM_REGS);

    rd_state_t     r_state, r_nxt;
    logic          ar_hs, ar_hit;
    logic [IW-1:0] ar_idx;

    axil_reg_bridge_wr #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_wr (
        .CLK       (CLK),
        .RST       (RST),
        .S_AWADDR  (S_AWADDR),
        .S_AWVALID (S_AWVALID),
        .S_AWREADY (S_AWREADY),
        .S_WDATA   (S_WDATA),
        .S_WSTRB   (S_WSTRB),
        .S_WVALID  (S_WVALID),
        .S_WREADY  (S_WREADY),
        .S_BRESP   (S_BRESP),
        .S_BVALID  (S_BVALID),
        .S_BREADY  (S_BREADY),
        .REG_WEN   (REG_WEN),
        .REG_WDATA (REG_WDATA),
        .REG_RDATA (REG_RDATA)
    );

    assign S_ARREADY = !RST && r_state == R_IDLE;
    assign S_RVALID  = r_state == R_RESP;
    assign ar_hs     = S_ARVALID && S_ARREADY;
    assign ar_hit    = (S_ARADDR >> 2) < NREG;
    assign ar_idx    = S_ARADDR[IW+1:2];

    always_comb begin
        r_nxt = r_state;
        case (r_state)
            R_IDLE:  r_nxt = ar_hs ? R_RESP : R_IDLE;
            R_RESP:  r_nxt = S_RREADY ? R_IDLE : R_RESP;
            default: r_nxt = R_IDLE;
        endcase
    end

    // Data is captured at the AR handshake, so a same-edge bank write is not yet visible.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= R_IDLE;
            S_RDATA <= '0;
            S_RRESP <= RESP_OKAY;
        end else begin
            r_state <= r_nxt;
            if (ar_hs) begin
                S_RDATA <= ar_hit ? REG_RDATA[ar_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
                S_RRESP <= ar_hit ? RESP_OKAY : RESP_MISS;
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb_axil_reg_bridge: directed self-checking bench for axil_reg_bridge with a behavioural register bank.
module tb_axil_reg_bridge;

    localparam logic [1:0] MISS_RESP =
`ifdef AXIL_BRIDGE_SLVERR_EN
        2'b10;
`else
        2'b00;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [7:0]   S_AWADDR = '0;
    logic         S_AWVALID = 1'b0;
    logic         S_AWREADY;
    logic [31:0]  S_WDATA = '0;
    logic [3:0]   S_WSTRB = '0;
    logic         S_WVALID = 1'b0;
    logic         S_WREADY;
    logic [1:0]   S_BRESP;
    logic         S_BVALID;
    logic         S_BREADY = 1'b0;
    logic [7:0]   S_ARADDR = '0;
    logic         S_ARVALID = 1'b0;
    logic         S_ARREADY;
    logic [31:0]  S_RDATA;
    logic [1:0]   S_RRESP;
    logic         S_RVALID;
    logic         S_RREADY = 1'b0;
    logic [7:0]   REG_WEN;
    logic [31:0]  REG_WDATA;
    logic [255:0] REG_RDATA;

    logic [31:0]  bank [8] = '{32'h0, 32'h0, 32'h5A5A0001, 32'h1, 32'h0, 32'h0, 32'h0, 32'h11223344};
    int           vec_cnt = 0;
    int           err_cnt = 0;
    int           wen_cnt = 0;
    logic [7:0]   wen_last = '0;

    axil_reg_bridge dut (
        .CLK       (CLK),
        .RST       (RST),
        .S_AWADDR  (S_AWADDR),
        .S_AWVALID (S_AWVALID),
        .S_AWREADY (S_AWREADY),
        .S_WDATA   (S_WDATA),
        .S_WSTRB   (S_WSTRB),
        .S_WVALID  (S_WVALID),
        .S_WREADY  (S_WREADY),
        .S_BRESP   (S_BRESP),
        .S_BVALID  (S_BVALID),
        .S_BREADY  (S_BREADY),
        .S_ARADDR  (S_ARADDR),
        .S_ARVALID (S_ARVALID),
        .S_ARREADY (S_ARREADY),
        .S_RDATA   (S_RDATA),
        .S_RRESP   (S_RRESP),
        .S_RVALID  (S_RVALID),
        .S_RREADY  (S_RREADY),
        .REG_WEN   (REG_WEN),
        .REG_WDATA (REG_WDATA),
        .REG_RDATA (REG_RDATA)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        REG_RDATA = '0;
        for (int i = 0; i < 8; i++)
            REG_RDATA[i*32 +: 32] = bank[i];
    end

    always @(posedge CLK) begin
        for (int i = 0; i < 8; i++)
            if (REG_WEN[i]) bank[i] <= REG_WDATA;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (REG_WEN != 0) begin
            wen_cnt  <= wen_cnt + 1;
            wen_last <= REG_WEN;
            check("wen_onehot", 32'($onehot(REG_WEN)), 32'd1);
        end
    end

    task automatic wait_b(output logic [1:0] r);
        logic got = 1'b0;
        r = '0;
        S_BREADY = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            if (S_BVALID) begin
                r   = S_BRESP;
                got = 1'b1;
            end
            @(posedge CLK); #1;
        end
        S_BREADY = 1'b0;
        if (!got) check("b_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
        logic aw, w;
        S_AWADDR = a; S_AWVALID = 1'b1;
        S_WDATA  = d; S_WSTRB = s; S_WVALID = 1'b1;
        for (int n = 0; n < 20 && (S_AWVALID || S_WVALID); n++) begin
            aw = S_AWVALID && S_AWREADY;
            w  = S_WVALID && S_WREADY;
            @(posedge CLK); #1;
            if (aw) S_AWVALID = 1'b0;
            if (w) S_WVALID = 1'b0;
        end
        if (S_AWVALID || S_WVALID) begin
            check("aw_w_timeout", 32'd1, 32'd0);
            S_AWVALID = 1'b0;
            S_WVALID  = 1'b0;
        end
        wait_b(r);
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        logic got = 1'b0;
        d = '0;
        r = '0;
        S_ARADDR = a; S_ARVALID = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            got = S_ARREADY;
            @(posedge CLK); #1;
        end
        S_ARVALID = 1'b0;
        if (!got) check("ar_timeout", 32'd1, 32'd0);
        got = 1'b0;
        S_RREADY = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            if (S_RVALID) begin
                d   = S_RDATA;
                r   = S_RRESP;
                got = 1'b1;
            end
            @(posedge CLK); #1;
        end
        S_RREADY = 1'b0;
        if (!got) check("r_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        int          w0;

        #1;
        check("rst_awready", 32'(S_AWREADY), 32'd0);
        check("rst_wready", 32'(S_WREADY), 32'd0);
        check("rst_arready", 32'(S_ARREADY), 32'd0);
        check("rst_valids", {30'd0, S_BVALID, S_RVALID}, 32'd0);
        check("rst_wen", 32'(REG_WEN), 32'd0);
        check("rst_rdata", S_RDATA, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // 1: AW and W in the same cycle
        S_AWADDR = 8'h04; S_AWVALID = 1'b1;
        S_WDATA = 32'hDEADBEEF; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        @(posedge CLK); #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        check("t1_wen", 32'(REG_WEN), 32'h02);
        check("t1_wdata", REG_WDATA, 32'hDEADBEEF);
        check("t1_bvalid_early", 32'(S_BVALID), 32'd0);
        wait_b(r);
        check("t1_bresp", 32'(r), 32'd0);
        check("t1_wen_count", 32'(wen_cnt), 32'd1);
        check("t1_bank1", bank[1], 32'hDEADBEEF);

        // 2: W three cycles ahead of AW, partial strobe merge
        S_WDATA = 32'hAABBCCDD; S_WSTRB = 4'b0101; S_WVALID = 1'b1;
        @(posedge CLK); #1;
        S_WVALID = 1'b0;
        check("t2_wready_have_w", 32'(S_WREADY), 32'd0);
        check("t2_awready_have_w", 32'(S_AWREADY), 32'd1);
        repeat (2) begin @(posedge CLK); #1; end
        check("t2_no_early_wen", 32'(wen_cnt), 32'd1);
        S_AWADDR = 8'h1C; S_AWVALID = 1'b1;
        @(posedge CLK); #1;
        S_AWVALID = 1'b0;
        check("t2_wen", 32'(REG_WEN), 32'h80);
        check("t2_wdata", REG_WDATA, 32'h11BB33DD);
        wait_b(r);
        check("t2_bresp", 32'(r), 32'd0);
        check("t2_bank7", bank[7], 32'h11BB33DD);

        // 3: read with RREADY held low for 4 cycles
        S_ARADDR = 8'h08; S_ARVALID = 1'b1;
        @(posedge CLK); #1;
        S_ARVALID = 1'b0;
        check("t3_rvalid", 32'(S_RVALID), 32'd1);
        check("t3_rdata", S_RDATA, 32'h5A5A0001);
        check("t3_rresp", 32'(S_RRESP), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            check("t3_rvalid_held", 32'(S_RVALID), 32'd1);
            check("t3_rdata_stable", S_RDATA, 32'h5A5A0001);
        end
        S_RREADY = 1'b1;
        @(posedge CLK); #1;
        S_RREADY = 1'b0;
        check("t3_rvalid_drop", 32'(S_RVALID), 32'd0);
        check("t3_arready_back", 32'(S_ARREADY), 32'd1);

        // 4: write and read an out-of-range address
        w0 = wen_cnt;
        do_write(8'h20, 32'h12345678, 4'hF, r);
        check("t4_bresp", 32'(r), 32'(MISS_RESP));
        check("t4_no_wen", 32'(wen_cnt), 32'(w0));
        do_read(8'h20, d, r);
        check("t4_rdata", d, 32'd0);
        check("t4_rresp", 32'(r), 32'(MISS_RESP));

        // 5: read sampled on the same edge the write lands
        S_AWADDR = 8'h0C; S_AWVALID = 1'b1;
        S_WDATA = 32'h2; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        @(posedge CLK); #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        S_ARADDR = 8'h0C; S_ARVALID = 1'b1;
        check("t5_wen", 32'(REG_WEN), 32'h08);
        @(posedge CLK); #1;
        S_ARVALID = 1'b0;
        check("t5_rvalid", 32'(S_RVALID), 32'd1);
        check("t5_rdata_old", S_RDATA, 32'h1);
        S_RREADY = 1'b1;
        wait_b(r);
        S_RREADY = 1'b0;
        check("t5_bresp", 32'(r), 32'd0);
        do_read(8'h0C, d, r);
        check("t5_rdata_new", d, 32'h2);

        // 6: reset while holding an address with no data
        S_AWADDR = 8'h10; S_AWVALID = 1'b1;
        @(posedge CLK); #1;
        S_AWVALID = 1'b0;
        check("t6_awready_have_aw", 32'(S_AWREADY), 32'd0);
        check("t6_wready_have_aw", 32'(S_WREADY), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("t6_rst_readies", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd0);
        check("t6_rst_valids", {30'd0, S_BVALID, S_RVALID}, 32'd0);
        check("t6_rst_wen", 32'(REG_WEN), 32'd0);
        check("t6_rst_rdata", S_RDATA, 32'd0);
        check("t6_rst_resps", {28'd0, S_BRESP, S_RRESP}, 32'd0);
        #2 RST = 1'b0;
        w0 = wen_cnt;
        repeat (3) begin @(posedge CLK); #1; end
        check("t6_no_wen_after_rst", 32'(wen_cnt), 32'(w0));
        do_write(8'h10, 32'hCAFEF00D, 4'hF, r);
        check("t6_bresp", 32'(r), 32'd0);
        check("t6_wen_count", 32'(wen_cnt), 32'(w0 + 1));
        check("t6_wen_last", 32'(wen_last), 32'h10);
        check("t6_bank4", bank[4], 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
